// File: rtl/gray_angle_stepper_ctrl.sv
// Gray-coded angle position sequencer: accepts a target sector and walks
// the 3-bit Gray position bus one step at a time at a programmable rate.
module gray_angle_stepper_ctrl #(
  parameter int STEP_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_target,
  input  logic       cmd_mode,
  input  logic       abort,
  output logic [2:0] one_hot,
  output logic [2:0] pos_idx,
  output logic       dir,
  output logic       step_pulse,
  output logic       busy,
  output logic       done
);

  localparam int CW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(STEP_DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    PLAN,
    STEP_WAIT,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    tgt_q, tgt_d;
  logic          mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    steps_q, steps_d;
  logic [2:0]    pos_q, pos_d;
  logic          dir_q, dir_d;
  logic          step_q, step_d;
  logic          done_q, done_d;
  logic [2:0]    gray_q, gray_d;
  logic [2:0]    delta;

  function automatic logic [2:0] to_gray(input logic [2:0] v);
    return v ^ (v >> 1);
  endfunction

  assign delta = tgt_q - pos_q;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    steps_d = steps_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          tgt_d   = cmd_target;
          mode_d  = cmd_mode;
          state_d = PLAN;
        end
      end
      PLAN: begin
        cnt_d = '0;
        // delta of exactly 4 is a tie and resolves clockwise
        if (mode_q || delta <= 3'd4) begin
          dir_d   = 1'b1;
          steps_d = delta;
        end else begin
          dir_d   = 1'b0;
          steps_d = 3'd0 - delta;
        end
        if (abort || steps_d == 3'd0) begin
          state_d = DONE;
        end else begin
          state_d = STEP_WAIT;
        end
      end
      STEP_WAIT: begin
        if (abort) begin
          cnt_d   = '0;
          state_d = DONE;
        end else if (cnt_q == TC) begin
          cnt_d   = '0;
          pos_d   = dir_q ? pos_q + 3'd1 : pos_q - 3'd1;
          step_d  = 1'b1;
          steps_d = steps_q - 3'd1;
          if (steps_d == 3'd0) begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    done_d = (state_d == DONE);
    gray_d = to_gray(pos_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      tgt_q   <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      steps_q <= '0;
      pos_q   <= '0;
      dir_q   <= 1'b0;
      step_q  <= 1'b0;
      done_q  <= 1'b0;
      gray_q  <= '0;
    end else begin
      state_q <= state_d;
      tgt_q   <= tgt_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      steps_q <= steps_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      step_q  <= step_d;
      done_q  <= done_d;
      gray_q  <= gray_d;
    end
  end

  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign one_hot    = gray_q;
  assign pos_idx    = pos_q;
  assign dir        = dir_q;
  assign step_pulse = step_q;
  assign done       = done_q;

endmodule

// File: tb/tb_gray_angle_stepper_ctrl.sv
// Bench for gray_angle_stepper_ctrl: directed moves plus random commands
// checked cycle by cycle against a timeline model of each move.
module tb_gray_angle_stepper_ctrl;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_target = 3'd0;
  logic       cmd_mode = 1'b0;
  logic       abort = 1'b0;
  logic [2:0] one_hot;
  logic [2:0] pos_idx;
  logic       dir;
  logic       step_pulse;
  logic       busy;
  logic       done;

  int total = 0;
  int bad = 0;
  int mpos = 0;
  logic [2:0] gtab [8] = '{3'b000, 3'b001, 3'b011, 3'b010,
                           3'b110, 3'b111, 3'b101, 3'b100};

  gray_angle_stepper_ctrl #(.STEP_DIV(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_target(cmd_target), .cmd_mode(cmd_mode),
    .abort(abort), .one_hot(one_hot), .pos_idx(pos_idx),
    .dir(dir), .step_pulse(step_pulse), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // obs/exp layout: one_hot, pos_idx, dir, step_pulse, done, busy, cmd_ready
  function automatic logic [10:0] obs();
    return {one_hot, pos_idx, dir, step_pulse, done, busy, cmd_ready};
  endfunction

  task automatic run_move(input int tgt, input int mode,
                          input int abort_k, input string name);
    int delta, n, d, start, act, end_e, taken;
    logic [2:0] p;
    logic ep;
    logic [10:0] exp_v;
    start = mpos;
    delta = (tgt - mpos + 8) % 8;
    if (mode != 0 || delta <= 4) begin
      d = 1; n = delta;
    end else begin
      d = 0; n = 8 - delta;
    end
    if (abort_k > n) abort_k = 0;
    act = (abort_k != 0) ? abort_k - 1 : n;
    end_e = (abort_k != 0) ? 1 + D * abort_k : ((n == 0) ? 1 : 1 + D * n);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL %s ready_before_cmd got %b exp 1", name, cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_target = 3'(tgt);
    cmd_mode = mode[0];
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_target = 3'($urandom);
    cmd_mode = 1'($urandom);
    for (int e = 1; e <= end_e + 1; e++) begin
      @(posedge clk); #1;
      abort = 1'b0;
      taken = (e - 1) / D;
      if (taken > act) taken = act;
      p = 3'((start + (d != 0 ? taken : 8 - taken)) % 8);
      ep = (e > 1) && ((e - 1) % D == 0) && ((e - 1) / D <= act);
      exp_v = {gtab[p], p, d[0], ep, (e == end_e), (e <= end_e),
               (e > end_e)};
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL %s cyc=%0d got %b exp %b", name, e, obs(), exp_v);
      end
      if (abort_k != 0 && e == D * abort_k) abort = 1'b1;
    end
    mpos = (start + (d != 0 ? act : 8 - act)) % 8;
  endtask

  task automatic test_reset();
    cmd_valid = 1'b1;
    cmd_target = 3'd5;
    #1 rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== 11'b000_000_0_0_0_0_1) begin
      bad++;
      $display("FAIL reset_hold got %b exp 00000000001", obs());
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (obs() !== 11'b000_000_0_0_0_0_1) begin
      bad++;
      $display("FAIL reset_no_accept got %b exp 00000000001", obs());
    end
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    total++;
    if (obs() !== 11'b000_000_0_0_0_0_1) begin
      bad++;
      $display("FAIL reset_release got %b exp 00000000001", obs());
    end
    mpos = 0;
  endtask

  task automatic test_zero_step();
    run_move(0, 0, 0, "zero_step");
  endtask

  task automatic test_short_cw();
    run_move(3, 0, 0, "short_cw");
  endtask

  task automatic test_short_ccw();
    run_move(0, 0, 0, "to_zero");
    run_move(6, 0, 0, "short_ccw");
  endtask

  task automatic test_tie_forced();
    run_move(2, 0, 0, "to_two");
    run_move(6, 0, 0, "tie_cw");
    run_move(5, 1, 0, "forced_cw_wrap");
  endtask

  task automatic test_abort();
    run_move(0, 0, 0, "to_zero_b");
    run_move(4, 0, 2, "abort_step2");
  endtask

  task automatic test_reset_mid_move();
    cmd_valid = 1'b1;
    cmd_target = 3'd4;
    cmd_mode = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL mid_move_busy got %b exp 1", busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (obs() !== 11'b000_000_0_0_0_0_1) begin
      bad++;
      $display("FAIL async_reset got %b exp 00000000001", obs());
    end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (i == 3) rst_n = 1'b1;
      total++;
      if (obs() !== 11'b000_000_0_0_0_0_1) begin
        bad++;
        $display("FAIL reset_no_done cyc=%0d got %b exp 00000000001",
                 i, obs());
      end
    end
    mpos = 0;
  endtask

  task automatic test_back_to_back();
    run_move(7, 0, 0, "b2b_a");
    run_move(3, 1, 0, "b2b_b");
    run_move(3, 0, 0, "b2b_zero");
  endtask

  task automatic test_random();
    int t, m, ak;
    for (int i = 0; i < 25; i++) begin
      t = $urandom_range(0, 7);
      m = $urandom_range(0, 1);
      ak = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      run_move(t, m, ak, "random");
    end
  endtask

  initial begin
    test_reset();
    test_zero_step();
    test_short_cw();
    test_short_ccw();
    test_tie_forced();
    test_abort();
    test_reset_mid_move();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_angle_stepper_ctrl.md
# gray_angle_stepper_ctrl

Sequencing controller for the 3-bit Gray-coded angle position bus (45° sectors, 0°–315°) that feeds the angle-to-BCD/degrees display converter. It accepts a target sector through a valid/ready command port. It then walks the position bus one Gray step at a time, at a programmable step rate, by the shortest path or forced clockwise. Step and completion strobes go to the motor-drive and status logic.

## Interface
Parameters:
- STEP_DIV, default 4: clock cycles per position step. Legal range is 1 to 65535. The step counter width is max(1, clog2(STEP_DIV)).

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high exactly when state is IDLE (combinational from state)
- cmd_target  in  3  target sector index, binary 0–7 (sector k = k×45°)
- cmd_mode  in  1  0 = shortest path; 1 = forced clockwise
- abort  in  1  terminate the move in progress
- one_hot  out  3  current position in Gray code (idx ^ (idx>>1)), registered
- pos_idx  out  3  current position, binary, registered
- dir  out  1  1 = clockwise (idx increasing), 0 = counter-clockwise, registered
- step_pulse  out  1  one-cycle strobe per position change, registered
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion strobe, registered

## Operation
- Gray sequence for idx 0..7 is 000, 001, 011, 010, 110, 111, 101, 100.
- Clockwise step: idx+1 mod 8, so 7 wraps to 0. Counter-clockwise step: idx−1 mod 8, so 0 wraps to 7.
- States are IDLE, PLAN, STEP_WAIT and DONE.
- IDLE → PLAN when cmd_valid && cmd_ready at a clock edge. cmd_target and cmd_mode are latched on that edge; later input changes are ignored.
- In PLAN, compute delta = (target − pos_idx) mod 8, 3-bit unsigned.
  - mode 1: dir=1, steps=delta.
  - mode 0 with delta ≤ 4: dir=1, steps=delta. A tie at 4 goes clockwise.
  - mode 0 with delta > 4: dir=0, steps=8−delta.
  - dir is written in PLAN. It is held until the next PLAN, including when steps=0.
  - steps=0 → DONE. Otherwise → STEP_WAIT with the counter cleared.
- In STEP_WAIT, the counter increments every cycle. When it reaches STEP_DIV−1:
  - pos_idx and one_hot advance one step in direction dir;
  - step_pulse=1 for the next cycle;
  - steps decrements and the counter clears.
  - When the decremented steps reaches 0, the state goes to DONE on the same edge.
- In DONE, done=1 for exactly one cycle, then the state returns to IDLE.
- abort is sampled in PLAN and STEP_WAIT only:
  - it sends the state to DONE on that edge and the partial count is discarded;
  - if it coincides with a step terminal count, abort wins and no step occurs;
  - it is ignored in IDLE and DONE.
- The position persists across commands. The only position initialisation is reset.

## Timing
- Reset values, held while rst_n is low and applied asynchronously:
  - state IDLE;
  - pos_idx 0, one_hot 000;
  - dir 0, step_pulse 0, done 0, busy 0;
  - counter 0, steps 0;
  - cmd_ready reads 1, but no command is accepted while rst_n is low.
- Name the accept edge E0. The state is PLAN in the cycle after E0.
- Step k (k = 1..n) becomes visible on one_hot after edge E0 + 1 + k×STEP_DIV.
- The last step's step_pulse coincides with done. cmd_ready returns one cycle later.
- A zero-step move: done is high in the cycle after E0+1, i.e. 2 cycles after accept. No step_pulse occurs.
- Back-to-back commands: the earliest next accept is the edge at the end of the first IDLE cycle after DONE.
- Reset asserted mid-move: all outputs return to their reset values immediately and position returns to 0. No done is generated.
- STEP_DIV=1: one step per cycle, with step_pulse high continuously for n cycles.

## Test plan
- Reset release → one_hot=000, pos_idx=0, cmd_ready=1, busy=0, done=0. Then command target 0 → done 2 cycles after accept, no step_pulse, dir=1.
- STEP_DIV=4, pos 0, target 3, mode 0 → dir=1; one_hot shows 001, 011, 010 at 4-cycle spacing. done is high together with the third step_pulse, 13 edges after accept.
- Pos 0, target 6, mode 0 (delta 6) → dir=0, 2 steps, one_hot 100 then 101, pos_idx=6, done after 9 edges.
- Tie and forced clockwise:
  - pos 2, target 6, mode 0 → dir=1, 4 steps, ending at one_hot 101;
  - then target 5, mode 1 → 7 clockwise steps through the 7→0 wrap, ending at pos_idx 5 (111).
- Abort and reset mid-move:
  - Pos 0, target 4; abort asserted in the same cycle as the 2nd step's terminal count → the step is suppressed, pos stays 1 (001), done pulses once, then IDLE.
  - Repeat the move, then drop rst_n mid-move → outputs reset immediately and no done is generated.
